// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks the row pointer once through the array, then pulses done.
`default_nettype none

module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              row_clr,
  output logic [ADDR_W-1:0] row_idx
);

  state_e            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ptr <= '0;
          if (clr_req) state <= CLEAR;
        end
        CLEAR: begin
          // Hold the pointer on the last row so it never wraps.
          if (ptr == '1) state <= DONE;
          else           ptr   <= ptr + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          ptr   <= '0;
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);
  assign row_clr  = (state == CLEAR);
  assign row_idx  = ptr;

endmodule

`default_nettype wire

// File: rtl/regfile_seq.sv
// Register file with two combinational read ports, one write port, dirty bitmap
// and a sequenced row-by-row clear.
`default_nettype none

module regfile_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [DATA_W-1:0]    wd,
  output logic                 wr_drop,
  input  logic [ADDR_W-1:0]    ra1,
  input  logic [ADDR_W-1:0]    ra2,
  output logic [DATA_W-1:0]    rd1,
  output logic [DATA_W-1:0]    rd2,
  output logic [2**ADDR_W-1:0] dirty
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              row_clr;
  logic [ADDR_W-1:0] row_idx;
  logic              r0_block;
  logic              wr_ok;
  logic              drop_nxt;

  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .row_clr  (row_clr),
    .row_idx  (row_idx)
  );

  // Hardwired-zero writes vanish silently; anything else blocked by a clear is reported.
  assign r0_block = (ZERO_R0 != 0) && (wa == '0);
  assign wr_ok    = we && !clr_busy && !clr_req && !r0_block;
  assign drop_nxt = we && (clr_busy || clr_req) && !r0_block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dirty   <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_nxt;
      if (row_clr) begin
        mem[row_idx]   <= '0;
        dirty[row_idx] <= 1'b0;
      end else if (wr_ok) begin
        mem[wa]   <= wd;
        dirty[wa] <= 1'b1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    if (clr_busy)                          return '0;
    if ((ZERO_R0 != 0) && (ra == '0))      return '0;
    if ((BYPASS != 0) && wr_ok && wa == ra) return wd;
    return mem[ra];
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_seq.sv
// Randomised and directed bench comparing four register-file variants to a behavioural model.
`default_nettype none

module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd = '0;

  logic [15:0] rd1_a [3], rd2_a [3], dirty_a [3];
  logic        busy_a [3], done_a [3], drop_a [3];
  logic [31:0] rd1_3, rd2_3, dirty_3;
  logic        busy_3, done_3, drop_3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_seq #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_a[0]), .clr_done(done_a[0]),
    .we(we), .wa(wa[3:0]), .wd(wd[15:0]), .wr_drop(drop_a[0]),
    .ra1(ra1[3:0]), .ra2(ra2[3:0]), .rd1(rd1_a[0]), .rd2(rd2_a[0]), .dirty(dirty_a[0]));
  regfile_seq #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_a[1]), .clr_done(done_a[1]),
    .we(we), .wa(wa[3:0]), .wd(wd[15:0]), .wr_drop(drop_a[1]),
    .ra1(ra1[3:0]), .ra2(ra2[3:0]), .rd1(rd1_a[1]), .rd2(rd2_a[1]), .dirty(dirty_a[1]));
  regfile_seq #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_a[2]), .clr_done(done_a[2]),
    .we(we), .wa(wa[3:0]), .wd(wd[15:0]), .wr_drop(drop_a[2]),
    .ra1(ra1[3:0]), .ra2(ra2[3:0]), .rd1(rd1_a[2]), .rd2(rd2_a[2]), .dirty(dirty_a[2]));
  regfile_seq #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(1)) u3 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy_3), .clr_done(done_3),
    .we(we), .wa(wa), .wd(wd), .wr_drop(drop_3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_3), .rd2(rd2_3), .dirty(dirty_3));

  // Reference model: per-variant memory image, dirty set, and clear countdown.
  int          dep [4] = '{16, 16, 16, 32};
  bit          zr0 [4] = '{0, 0, 1, 0};
  bit          byp [4] = '{1, 0, 1, 1};
  logic [31:0] dmask [4] = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF_FFFF};
  logic [31:0] mem_m [4][32];
  logic [31:0] dirty_m [4];
  int          cnt_m [4];
  logic        drop_m [4];
  int          busy_seen [4];
  int          done_seen [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 32; r++) mem_m[i][r] = '0;
      dirty_m[i] = '0;
      cnt_m[i]   = 0;
      drop_m[i]  = 1'b0;
    end
  endtask

  function automatic logic blocked(input int i, input logic [4:0] a);
    return zr0[i] && (int'(a) % dep[i] == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] ra);
    int r = int'(ra) % dep[i];
    int a = int'(wa) % dep[i];
    if (cnt_m[i] > 0) return '0;
    if (zr0[i] && r == 0) return '0;
    if (byp[i] && we && !clr_req && !blocked(i, wa) && a == r) return wd & dmask[i];
    return mem_m[i][r];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int a = int'(wa) % dep[i];
      drop_m[i] = we && (cnt_m[i] > 0 || clr_req) && !blocked(i, wa);
      // Rows 0..DEPTH-1 are wiped on the DEPTH edges following the request.
      if (cnt_m[i] >= 2) begin
        mem_m[i][dep[i] + 1 - cnt_m[i]] = '0;
        dirty_m[i][dep[i] + 1 - cnt_m[i]] = 1'b0;
      end
      if (we && cnt_m[i] == 0 && !clr_req && !blocked(i, wa)) begin
        mem_m[i][a]   = wd & dmask[i];
        dirty_m[i][a] = 1'b1;
      end
      if (cnt_m[i] > 0) cnt_m[i]--;
      else if (clr_req) cnt_m[i] = dep[i] + 1;
    end
  endtask

  task automatic check_all();
    logic [31:0] g_rd1, g_rd2, g_dirty, dmsk;
    logic        g_busy, g_done, g_drop;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        g_rd1 = 32'(rd1_a[i]); g_rd2 = 32'(rd2_a[i]); g_dirty = 32'(dirty_a[i]);
        g_busy = busy_a[i]; g_done = done_a[i]; g_drop = drop_a[i];
      end else begin
        g_rd1 = rd1_3; g_rd2 = rd2_3; g_dirty = dirty_3;
        g_busy = busy_3; g_done = done_3; g_drop = drop_3;
      end
      dmsk = (dep[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dep[i]) - 32'd1);
      busy_seen[i] += int'(g_busy);
      done_seen[i] += int'(g_done);
      chk($sformatf("u%0d_rd1", i), g_rd1, exp_rd(i, ra1));
      chk($sformatf("u%0d_rd2", i), g_rd2, exp_rd(i, ra2));
      chk($sformatf("u%0d_dirty", i), g_dirty, dirty_m[i] & dmsk);
      chk($sformatf("u%0d_busy", i), 32'(g_busy), 32'(cnt_m[i] > 0));
      chk($sformatf("u%0d_done", i), 32'(g_done), 32'(cnt_m[i] == 1));
      chk($sformatf("u%0d_drop", i), 32'(g_drop), 32'(drop_m[i]));
    end
  endtask

  // Called at a falling edge: apply inputs, check, then advance one clock.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic c);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; clr_req = c;
    #1 check_all();
  endtask

  task automatic edge_adv();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic c);
    drive(w, a, d, r1, r2, c);
    edge_adv();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin busy_seen[i] = 0; done_seen[i] = 0; end
  endtask

  initial begin
    model_reset();
    clear_counts();
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic write/read.
    step(1, 3, 32'hBEEF, 0, 0, 0);
    step(1, 7, 32'h1234, 0, 0, 0);
    drive(0, 0, 0, 3, 7, 0);
    chk("wr_rd1", 32'(rd1_a[0]), 32'hBEEF);
    chk("wr_rd2", 32'(rd2_a[0]), 32'h1234);
    chk("wr_dirty", 32'(dirty_a[0]), 32'h0088);
    edge_adv();

    // Same-cycle bypass versus no bypass.
    drive(1, 5, 32'hA5A5, 5, 5, 0);
    chk("byp_on", 32'(rd1_a[0]), 32'hA5A5);
    chk("byp_off", 32'(rd1_a[1]), 32'h0);
    edge_adv();

    // Fill everything, then clear with writes in the request cycle and during the clear.
    for (int i = 0; i < 32; i++) step(1, 5'(i), $urandom, 5'($urandom), 5'($urandom), 0);
    clear_counts();
    step(1, 2, 32'h5555, 2, 3, 1);
    for (int j = 0; j < 40; j++)
      step(j < 5, 2, 32'h6666, 5'($urandom), 5'($urandom), j == 8);
    chk("clr_busy16", 32'(busy_seen[0]), 32'd17);
    chk("clr_busy32", 32'(busy_seen[3]), 32'd33);
    chk("clr_done16", 32'(done_seen[0]), 32'd1);
    chk("clr_done32", 32'(done_seen[3]), 32'd1);
    chk("clr_dirty", 32'(dirty_a[0]), 32'h0);

    // Reset in the middle of a clear.
    for (int i = 0; i < 8; i++) step(1, 5'(i), $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 1, 2, 0);
    clear_counts();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy_a[0]), 32'h0);
    chk("rst_dirty", 32'(dirty_a[0]), 32'h0);
    drive(0, 0, 0, 1, 2, 0);
    edge_adv();
    rst = 1'b0;
    step(1, 1, 32'h0077, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk("post_rst_rd", 32'(rd1_a[0]), 32'h0077);
    edge_adv();
    for (int j = 0; j < 4; j++) step(0, 0, 0, 1, 0, 0);
    chk("post_rst_done", 32'(done_seen[0]), 32'd0);

    // Hardwired-zero R0.
    step(1, 0, 32'hFFFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("r0_rd", 32'(rd1_a[2]), 32'h0);
    chk("r0_dirty", 32'(dirty_a[2][0]), 32'h0);
    chk("r0_drop", 32'(drop_a[2]), 32'h0);
    edge_adv();

    // Random traffic with occasional clears.
    for (int n = 0; n < 800; n++)
      step(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
           ($urandom % 50) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Parametrised successor to the CPU's 16x16 register bank: configurable width and depth, two combinational read ports, one synchronous write port.
- Adds an optional hardwired-zero R0 and optional write-to-read bypass.
- Adds a per-register dirty bitmap and a sequenced clear: one row per cycle, RAM-inferable, with busy/done handshake.
- Sits between the control FSM and the ALU datapath; the CLEAR instruction and power-down drive clr_req.

Parameters:
DATA_W, 16, data width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
ZERO_R0, 0, 1 = entry 0 reads as zero and ignores writes
BYPASS, 1, 1 = read port returns wd when we && wa==ra in the same cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr_req  in  1  single-cycle pulse requesting a full clear
clr_busy  out  1  high while the clear sequence runs
clr_done  out  1  one-cycle pulse after the last row is cleared
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
wr_drop  out  1  registered pulse: the previous cycle's write was discarded
ra1  in  ADDR_W  read address 1
ra2  in  ADDR_W  read address 2
rd1  out  DATA_W  read data 1, combinational
rd2  out  DATA_W  read data 2, combinational
dirty  out  DEPTH  bit i = entry i written since the last reset or clear

Behaviour:
- Reset (async, any state, including mid-clear): all entries 0, dirty 0, FSM IDLE, clear pointer 0, clr_busy/clr_done/wr_drop 0. The clear sequence is aborted.
- FSM states:
  - IDLE: on clr_req -> CLEAR; pointer = 0.
  - CLEAR: each cycle zeroes entry[ptr] and dirty[ptr], then ptr++. When ptr == DEPTH-1 -> DONE.
  - DONE: clr_done = 1 for exactly one cycle, then -> IDLE.
- clr_busy = 1 in CLEAR and DONE, registered.
- Clear latency: clr_req sampled at edge k; clr_busy high from k through k+DEPTH; clr_done high in the cycle after edge k+DEPTH. Total DEPTH+1 cycles busy.
- clr_req while clr_busy: ignored, no restart.
- Write, IDLE: at the rising edge, if we, entry[wa] <= wd and dirty[wa] <= 1.
- Write, CLEAR/DONE, or same cycle as an accepted clr_req: write discarded; wr_drop = 1 in the following cycle. Clear has priority.
- ZERO_R0=1:
  - Writes to address 0 are silently ignored (no wr_drop); dirty[0] stays 0.
  - Reads of address 0 return 0, with or without bypass.
- Reads in IDLE: rd = entry[ra]. If BYPASS=1 and we && wa==ra (and the write is not dropped or ZERO_R0-suppressed), rd = wd.
- Reads while clr_busy: rd1 = rd2 = 0 regardless of address. Reads are masked; no partially-cleared values are visible.
- ra1 == ra2: both ports return the same value.
- wr_drop: registered, one cycle per dropped write. Back-to-back drops produce back-to-back pulses.
- No arithmetic other than the ptr increment (ADDR_W bits); ptr never wraps because DONE is entered at DEPTH-1.

Decomposition:
- Package regfile_pkg: state enum {IDLE, CLEAR, DONE}; default DATA_W/ADDR_W localparams; a function computing DEPTH from ADDR_W.
- One sub-module, regfile_clr_fsm: state register, pointer, clr_busy/clr_done, and a row-zero strobe plus index to the storage.
- Storage array, read muxing, bypass, dirty bitmap and wr_drop stay in the top module.

Test Plan:
- Reset, then write 0xBEEF to R3 and 0x1234 to R7; read ra1=3, ra2=7 -> rd1=0xBEEF, rd2=0x1234, dirty=0x0088.
- BYPASS=1: we=1, wa=5, wd=0xA5A5, ra1=5 in the same cycle -> rd1=0xA5A5 that cycle. BYPASS=0 -> rd1 returns the old value (0).
- Fill all 16 entries, pulse clr_req at edge k -> clr_busy high k..k+16, clr_done single pulse after edge k+16, rd1/rd2=0 throughout, all entries 0 and dirty=0 after.
- we=1 wa=2 during CLEAR and in the same cycle as clr_req -> entry 2 stays 0, wr_drop pulses once per attempt in the following cycle; second clr_req mid-sequence does not extend busy.
- Assert rst at cycle 6 of a clear -> immediately clr_busy=0, all outputs 0; subsequent write and read of R1 works with no residual done pulse.
- ZERO_R0=1: write 0xFFFF to R0 -> rd=0, dirty[0]=0, wr_drop=0. Also run DATA_W=32, ADDR_W=5: clear takes 33 busy cycles.
